// File: rtl/control_unit_p_if.sv
// Datapath <-> control-unit signal bundle for control_unit_p.
// master = control unit side, slave = datapath/RAM/ALU side.
interface control_unit_p_if #(
  parameter int INS_W = 16,
  parameter int OPC_W = 4,
  parameter int RD_W  = 2,
  parameter int OFF_W = 8,
  parameter int CNT_W = 16
);
  logic                   en;
  logic [INS_W-1:0]       ins;
  logic                   en_ram_out;
  logic                   en_alu;
  logic                   alu_zero;

  logic                   en_ram_in;
  logic                   en_rf_pulse;
  logic                   en_pc_pulse;
  logic [(1<<RD_W)-1:0]   reg_en;
  logic                   alu_in_sel;
  logic [OPC_W-1:0]       alu_func;
  logic [1:0]             pc_ctrl;
  logic [OFF_W-1:0]       offset_addr;
  logic [CNT_W-1:0]       instr_cnt;
  logic                   trap;

  modport master (
    input  en, ins, en_ram_out, en_alu, alu_zero,
    output en_ram_in, en_rf_pulse, en_pc_pulse, reg_en, alu_in_sel,
           alu_func, pc_ctrl, offset_addr, instr_cnt, trap
  );

  modport slave (
    output en, ins, en_ram_out, en_alu, alu_zero,
    input  en_ram_in, en_rf_pulse, en_pc_pulse, reg_en, alu_in_sel,
           alu_func, pc_ctrl, offset_addr, instr_cnt, trap
  );
endinterface

// File: rtl/control_unit_p.sv
// control_unit_p: multi-cycle fetch/decode/execute sequencer for the CPU datapath.
// Define CU_ILLEGAL_TRAP_EN to halt on illegal opcodes; otherwise they run as NOP.
module control_unit_p #(
  parameter int INS_W = 16,
  parameter int OPC_W = 4,
  parameter int RD_W  = 2,
  parameter int OFF_W = 8,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  control_unit_p_if.master bus
);
  // state  | meaning
  // IDLE   | stopped, waiting for en
  // FETCH  | en_ram_in pulse
  // WAIT   | waiting for en_ram_out, IR capture
  // DECODE | latch alu_func/alu_in_sel/rd, resolve branch
  // EXEC   | waiting for en_alu
  // WB     | en_rf_pulse with one-hot reg_en
  // PCU    | en_pc_pulse with pc_ctrl, retire count
  // TRAP   | illegal opcode, held until rst

  localparam int REG_N = 1 << RD_W;
  localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(7);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_WB, S_PCU, S_TRAP
  } state_e;

  state_e             state_q;
  logic [INS_W-1:0]   ir_q;
  logic [OPC_W-1:0]   alu_func_q;
  logic               alu_in_sel_q;
  logic [RD_W-1:0]    rd_q;
  logic               en_ram_in_q;
  logic               en_rf_q;
  logic               en_pc_q;
  logic [REG_N-1:0]   reg_en_q;
  logic [1:0]         pc_ctrl_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [OPC_W-1:0]   opc;
  logic [RD_W-1:0]    rd;
  logic               is_alu;
  logic [1:0]         pc_ctrl_d;

  assign opc    = ir_q[INS_W-1 -: OPC_W];
  assign rd     = ir_q[INS_W-OPC_W-1 -: RD_W];
  assign is_alu = (opc >= OP_LDI) && (opc <= OP_OR);
  // Branch decision uses alu_zero as seen during DECODE.
  assign pc_ctrl_d = ((opc == OP_JMP) || ((opc == OP_JZ) && bus.alu_zero)) ? 2'b10 : 2'b01;

`ifdef CU_ILLEGAL_TRAP_EN
  logic trap_q;
  logic is_illegal;
  assign is_illegal = opc > OPC_W'(7);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ir_q         <= '0;
      alu_func_q   <= '0;
      alu_in_sel_q <= 1'b0;
      rd_q         <= '0;
      en_ram_in_q  <= 1'b0;
      en_rf_q      <= 1'b0;
      en_pc_q      <= 1'b0;
      reg_en_q     <= '0;
      pc_ctrl_q    <= 2'b00;
      cnt_q        <= '0;
`ifdef CU_ILLEGAL_TRAP_EN
      trap_q       <= 1'b0;
`endif
    end else begin
      en_ram_in_q <= 1'b0;
      en_rf_q     <= 1'b0;
      en_pc_q     <= 1'b0;
      reg_en_q    <= '0;
      pc_ctrl_q   <= 2'b00;
      case (state_q)
        S_IDLE: begin
          if (bus.en) begin
            state_q     <= S_FETCH;
            en_ram_in_q <= 1'b1;
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          if (bus.en_ram_out) begin
            ir_q    <= bus.ins;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          alu_func_q   <= opc;
          alu_in_sel_q <= (opc == OP_LDI);
          rd_q         <= rd;
          if (is_alu) begin
            state_q <= S_EXEC;
          end
`ifdef CU_ILLEGAL_TRAP_EN
          else if (is_illegal) begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
          end
`endif
          else begin
            state_q   <= S_PCU;
            en_pc_q   <= 1'b1;
            pc_ctrl_q <= pc_ctrl_d;
            cnt_q     <= cnt_q + CNT_W'(1);
          end
        end
        S_EXEC: begin
          if (bus.en_alu) begin
            state_q  <= S_WB;
            en_rf_q  <= 1'b1;
            reg_en_q <= REG_N'(1) << rd_q;
          end
        end
        S_WB: begin
          state_q   <= S_PCU;
          en_pc_q   <= 1'b1;
          pc_ctrl_q <= 2'b01;
          cnt_q     <= cnt_q + CNT_W'(1);
        end
        S_PCU: begin
          if (bus.en) begin
            state_q     <= S_FETCH;
            en_ram_in_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
`ifdef CU_ILLEGAL_TRAP_EN
        S_TRAP: state_q <= S_TRAP;
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.en_ram_in   = en_ram_in_q;
  assign bus.en_rf_pulse = en_rf_q;
  assign bus.en_pc_pulse = en_pc_q;
  assign bus.reg_en      = reg_en_q;
  assign bus.alu_in_sel  = alu_in_sel_q;
  assign bus.alu_func    = alu_func_q;
  assign bus.pc_ctrl     = pc_ctrl_q;
  assign bus.offset_addr = ir_q[OFF_W-1:0];
  assign bus.instr_cnt   = cnt_q;
`ifdef CU_ILLEGAL_TRAP_EN
  assign bus.trap        = trap_q;
`else
  assign bus.trap        = 1'b0;
`endif
endmodule
